// File: rtl/unified_mem_arbiter_pkg.sv
// unified_mem_arbiter_pkg: shared owner encoding and default widths for the memory arbiter
package unified_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        NONE  = 2'd0,
        IF_RD = 2'd1,
        D_RD  = 2'd2
    } owner_t;

    localparam int DEF_ADDR_WIDTH   = 8;
    localparam int DEF_DATA_WIDTH   = 32;
    localparam int DEF_STARVE_LIMIT = 4;
    localparam int STARVE_WIDTH     = 4;
    localparam int CONFLICT_WIDTH   = 16;

endpackage

// File: rtl/unified_mem_arbiter_sat_counter.sv
// sat_counter: saturating up-counter with priority clear and synchronous active-low reset
module sat_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    // reset wins, then clear, then increment that sticks at all-ones
    always_ff @(posedge clock) begin
        if (!clear)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (inc && !(&count))
            count <= count + 1'b1;
    end

endmodule

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: shares one single-port RAM between fetch and data ports with starvation guard
module unified_mem_arbiter
    import unified_mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_grant,
    output logic                  if_rvalid,
    output logic [DATA_WIDTH-1:0] if_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_grant,
    output logic                  d_rvalid,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    output logic                  mem_wren,
    input  logic [DATA_WIDTH-1:0] mem_dout,
    output logic [15:0]           conflict_cnt
);

    owner_t                  owner, owner_next;
    logic [STARVE_WIDTH-1:0] starve_cnt;
    logic                    starve_hit;
    logic [DATA_WIDTH-1:0]   if_held, d_held;

    assign starve_hit = starve_cnt >= STARVE_WIDTH'(STARVE_LIMIT);

    // data wins ties unless fetch has waited long enough; all grants gated off during reset
    always_comb begin
        if_grant = clear && if_req && (!d_req || starve_hit);
        d_grant  = clear && d_req && !(if_req && starve_hit);
        mem_wren = d_grant && d_we;
        mem_addr = if_grant ? if_addr : d_grant ? d_addr : '0;
        mem_din  = d_grant ? d_wdata : '0;
    end

    // next owner of the read data returning one cycle after the grant
    always_comb begin
        owner_next = if_grant ? IF_RD : (d_grant && !d_we) ? D_RD : NONE;
    end

    // owner register drives the rvalid strobes
    always_ff @(posedge clock) begin
        if (!clear)
            owner <= NONE;
        else
            owner <= owner_next;
    end

    // hold the last delivered word per port so rdata stays stable between valids
    always_ff @(posedge clock) begin
        if (!clear) begin
            if_held <= '0;
            d_held  <= '0;
        end else begin
            if (owner == IF_RD)
                if_held <= mem_dout;
            if (owner == D_RD)
                d_held <= mem_dout;
        end
    end

    assign if_rvalid = owner == IF_RD;
    assign d_rvalid  = owner == D_RD;
    assign if_rdata  = if_rvalid ? mem_dout : if_held;
    assign d_rdata   = d_rvalid ? mem_dout : d_held;

    sat_counter #(.WIDTH(STARVE_WIDTH)) u_starve (
        .clock (clock),
        .clear (clear),
        .inc   (if_req && !if_grant),
        .clr   (!if_req || if_grant),
        .count (starve_cnt)
    );

    sat_counter #(.WIDTH(CONFLICT_WIDTH)) u_conflict (
        .clock (clock),
        .clear (clear),
        .inc   (if_req && d_req),
        .clr   (1'b0),
        .count (conflict_cnt)
    );

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb_unified_mem_arbiter: table vectors, reset sequence and randomized traffic against a reference model
module tb_unified_mem_arbiter;

    localparam int LIMIT = 4;

    logic        clock = 0;
    logic        clear = 0;
    logic        if_req = 0, d_req = 0, d_we = 0;
    logic [7:0]  if_addr = 0, d_addr = 0;
    logic [31:0] d_wdata = 0;
    logic        if_grant, if_rvalid, d_grant, d_rvalid, mem_wren;
    logic [31:0] if_rdata, d_rdata, mem_din, mem_dout;
    logic [7:0]  mem_addr;
    logic [15:0] conflict_cnt;

    typedef struct {
        bit         ir;
        logic [7:0] ia;
        bit         dr;
        bit         dwe;
        logic [7:0] da;
        logic [31:0] dw;
        bit         gi;
        bit         gd;
        bit         wr;
        bit         ifv;
        bit         dv;
        logic [31:0] dat;
    } vec_t;

    int total = 0;
    int bad = 0;

    // reference model state
    logic [31:0] ref_mem [256];
    int          denied, conf;
    bit          p_if, p_d, armed;
    logic [31:0] p_if_data, p_d_data, h_if, h_d;
    bit          eg_if, eg_d;
    vec_t        cur;
    bit          cur_c;

    // RAM: 1-cycle registered read, write lands before the next cycle's read
    logic [31:0] ram [256];
    bit          wr [256];
    always @(posedge clock) begin
        if (mem_wren) begin
            ram[mem_addr] <= mem_din;
            wr[mem_addr]  <= 1'b1;
        end
        mem_dout <= wr[mem_addr] ? ram[mem_addr] : 32'(mem_addr) + 32'h10;
    end

    always #5 clock = ~clock;

    unified_mem_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .STARVE_LIMIT(LIMIT)) dut (
        .clock        (clock),
        .clear        (clear),
        .if_req       (if_req),
        .if_addr      (if_addr),
        .if_grant     (if_grant),
        .if_rvalid    (if_rvalid),
        .if_rdata     (if_rdata),
        .d_req        (d_req),
        .d_we         (d_we),
        .d_addr       (d_addr),
        .d_wdata      (d_wdata),
        .d_grant      (d_grant),
        .d_rvalid     (d_rvalid),
        .d_rdata      (d_rdata),
        .mem_addr     (mem_addr),
        .mem_din      (mem_din),
        .mem_wren     (mem_wren),
        .mem_dout     (mem_dout),
        .conflict_cnt (conflict_cnt)
    );

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", n, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input int ir, input int ia, input int dr, input int dwe, input int da,
                                input logic [31:0] dw, input int gi, input int gd, input int wrn,
                                input int ifv, input int dv, input logic [31:0] dat);
        vec_t v;
        v.ir = bit'(ir); v.ia = 8'(ia); v.dr = bit'(dr); v.dwe = bit'(dwe); v.da = 8'(da); v.dw = dw;
        v.gi = bit'(gi); v.gd = bit'(gd); v.wr = bit'(wrn); v.ifv = bit'(ifv); v.dv = bit'(dv); v.dat = dat;
        return v;
    endfunction

    // drive one cycle's inputs at the falling edge and check everything against the model
    task automatic apply(input vec_t v, input bit c);
        @(negedge clock);
        cur = v; cur_c = c;
        clear = c; if_req = v.ir; if_addr = v.ia; d_req = v.dr; d_we = v.dwe; d_addr = v.da; d_wdata = v.dw;
        #1;
        eg_if = c && v.ir && (!v.dr || denied >= LIMIT);
        eg_d  = c && v.dr && !eg_if;
        chk("if_grant", 32'(if_grant), 32'(eg_if));
        chk("d_grant", 32'(d_grant), 32'(eg_d));
        chk("mem_wren", 32'(mem_wren), 32'(eg_d && v.dwe));
        chk("mem_addr", 32'(mem_addr), eg_if ? 32'(v.ia) : eg_d ? 32'(v.da) : 32'h0);
        chk("mem_din", mem_din, eg_d ? v.dw : 32'h0);
        if (armed) begin
            chk("if_rvalid", 32'(if_rvalid), 32'(p_if));
            chk("d_rvalid", 32'(d_rvalid), 32'(p_d));
            chk("if_rdata", if_rdata, p_if ? p_if_data : h_if);
            chk("d_rdata", d_rdata, p_d ? p_d_data : h_d);
            chk("conflict_cnt", 32'(conflict_cnt), 32'(conf));
        end
    endtask

    // advance across the rising edge and update the model from the cycle just applied
    task automatic advance();
        @(posedge clock);
        if (!cur_c) begin
            denied = 0; conf = 0; p_if = 0; p_d = 0; h_if = 0; h_d = 0; armed = 1;
        end else begin
            if (p_if) h_if = p_if_data;
            if (p_d) h_d = p_d_data;
            p_if = eg_if;
            p_if_data = ref_mem[cur.ia];
            p_d = eg_d && !cur.dwe;
            p_d_data = ref_mem[cur.da];
            if (eg_d && cur.dwe) ref_mem[cur.da] = cur.dw;
            denied = (cur.ir && !eg_if) ? ((denied < 15) ? denied + 1 : 15) : 0;
            if (cur.ir && cur.dr && conf < 65535) conf++;
        end
    endtask

    vec_t tbl [17];
    vec_t idle;

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = 32'(i) + 32'h10;
        armed = 0; denied = 0; conf = 0; p_if = 0; p_d = 0; h_if = 0; h_d = 0;
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        tbl[0]  = mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        tbl[1]  = mk(1, 1, 0, 0, 0, 0, 1, 0, 0, 1, 0, 32'h10);
        tbl[2]  = mk(1, 2, 0, 0, 0, 0, 1, 0, 0, 1, 0, 32'h11);
        tbl[3]  = mk(1, 3, 0, 0, 0, 0, 1, 0, 0, 1, 0, 32'h12);
        tbl[4]  = mk(1, 9, 1, 0, 5, 0, 0, 1, 0, 1, 0, 32'h13);
        tbl[5]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h15);
        tbl[6]  = mk(1, 8'h20, 1, 0, 8'h30, 0, 0, 1, 0, 0, 0, 0);
        tbl[7]  = mk(1, 8'h20, 1, 0, 8'h31, 0, 0, 1, 0, 0, 1, 32'h40);
        tbl[8]  = mk(1, 8'h20, 1, 0, 8'h32, 0, 0, 1, 0, 0, 1, 32'h41);
        tbl[9]  = mk(1, 8'h20, 1, 0, 8'h33, 0, 0, 1, 0, 0, 1, 32'h42);
        tbl[10] = mk(1, 8'h20, 1, 0, 8'h34, 0, 1, 0, 0, 0, 1, 32'h43);
        tbl[11] = mk(1, 8'h20, 1, 0, 8'h35, 0, 0, 1, 0, 1, 0, 32'h30);
        tbl[12] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h45);
        tbl[13] = mk(0, 0, 1, 1, 7, 32'hDEADBEEF, 0, 1, 1, 0, 0, 0);
        tbl[14] = mk(0, 0, 1, 0, 7, 0, 0, 1, 0, 0, 0, 0);
        tbl[15] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF);
        tbl[16] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // initial reset: outputs are unknown until the first clear edge, so only grants are checked
        apply(idle, 0); advance();
        apply(idle, 0); advance();
        apply(idle, 1);
        chk("rst_if_rvalid", 32'(if_rvalid), 0);
        chk("rst_d_rvalid", 32'(d_rvalid), 0);
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_d_rdata", d_rdata, 0);
        chk("rst_conflict", 32'(conflict_cnt), 0);
        advance();

        for (int i = 0; i < 17; i++) begin
            apply(tbl[i], 1);
            chk($sformatf("tbl%0d_if_grant", i), 32'(if_grant), 32'(tbl[i].gi));
            chk($sformatf("tbl%0d_d_grant", i), 32'(d_grant), 32'(tbl[i].gd));
            chk($sformatf("tbl%0d_wren", i), 32'(mem_wren), 32'(tbl[i].wr));
            chk($sformatf("tbl%0d_if_rvalid", i), 32'(if_rvalid), 32'(tbl[i].ifv));
            chk($sformatf("tbl%0d_d_rvalid", i), 32'(d_rvalid), 32'(tbl[i].dv));
            if (tbl[i].ifv) chk($sformatf("tbl%0d_if_rdata", i), if_rdata, tbl[i].dat);
            if (tbl[i].dv) chk($sformatf("tbl%0d_d_rdata", i), d_rdata, tbl[i].dat);
            advance();
        end
        apply(idle, 1);
        chk("held_after_write", d_rdata, 32'hDEADBEEF);
        chk("conflicts_so_far", 32'(conflict_cnt), 7);
        advance();

        // reset lands on the edge right after a fetch grant
        apply(mk(1, 4, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0), 1);
        chk("pre_rst_if_grant", 32'(if_grant), 1);
        advance();
        apply(mk(1, 4, 1, 1, 2, 32'h55, 0, 0, 0, 0, 0, 0), 0);
        chk("rst_grants_if", 32'(if_grant), 0);
        chk("rst_grants_d", 32'(d_grant), 0);
        chk("rst_wren", 32'(mem_wren), 0);
        advance();
        apply(mk(1, 4, 1, 0, 2, 0, 0, 0, 0, 0, 0, 0), 1);
        chk("post_rst_if_rvalid", 32'(if_rvalid), 0);
        chk("post_rst_if_rdata", if_rdata, 0);
        chk("post_rst_conflict", 32'(conflict_cnt), 0);
        chk("post_rst_d_grant", 32'(d_grant), 1);
        advance();
        apply(idle, 1);
        chk("post_rst_no_if_rvalid", 32'(if_rvalid), 0);
        advance();

        // randomized traffic, biased toward contention and a small address window
        for (int i = 0; i < 400; i++) begin
            vec_t v;
            v = idle;
            v.ir  = $urandom_range(0, 3) != 0;
            v.ia  = 8'($urandom_range(0, 15));
            v.dr  = $urandom_range(0, 3) != 0;
            v.dwe = $urandom_range(0, 2) == 0;
            v.da  = 8'($urandom_range(0, 15));
            v.dw  = $urandom;
            apply(v, $urandom_range(0, 39) != 0);
            advance();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Shares one single-port synchronous RAM between the instruction-fetch port and the data (MEM-stage) port of the 5-stage core.
- The RAM has 1-cycle read latency and a registered DOUT, the same timing as the existing IRAM/DataRAM.
- The arbiter grants one requester per cycle, routes address and write data to the RAM, and tags the returning read data back to its owner.
- It prevents fetch starvation and counts conflict cycles for debug LEDs.

Parameters:
- ADDR_WIDTH, 8, RAM word-address width.
- DATA_WIDTH, 32, data word width.
- STARVE_LIMIT, 4, consecutive denied fetch cycles after which fetch is forced to win one cycle (range 1..15).

Ports:
- clock  in  1  system clock, rising edge.
- clear  in  1  reset, synchronous, active-low.
- if_req  in  1  fetch read request; level, held until granted.
- if_addr  in  ADDR_WIDTH  fetch word address.
- if_grant  out  1  fetch granted this cycle (combinational).
- if_rvalid  out  1  if_rdata is new this cycle.
- if_rdata  out  DATA_WIDTH  fetch read data.
- d_req  in  1  data request; level, held until granted.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  ADDR_WIDTH  data word address.
- d_wdata  in  DATA_WIDTH  write data.
- d_grant  out  1  data granted this cycle (combinational).
- d_rvalid  out  1  d_rdata is new this cycle (reads only).
- d_rdata  out  DATA_WIDTH  data read data.
- mem_addr  out  ADDR_WIDTH  RAM address.
- mem_din  out  DATA_WIDTH  RAM write data.
- mem_wren  out  1  RAM write enable.
- mem_dout  in  DATA_WIDTH  RAM registered read data.
- conflict_cnt  out  16  saturating count of cycles with both requests active.

Behaviour:
- Reset is synchronous: only a rising clock edge with clear=0 resets state. While clear=0, if_grant, d_grant and mem_wren are forced 0. After that edge: starve_cnt=0, owner=NONE, if_rvalid=0, d_rvalid=0, both held-data regs=0, conflict_cnt=0.
- Arbitration is combinational from the current inputs and starve_cnt:
  - only one request active: that requester is granted.
  - both active: d wins, except when starve_cnt >= STARVE_LIMIT, in which case fetch wins.
  - neither active: no grant; mem_addr=0, mem_din=0, mem_wren=0.
- mem_addr and mem_din mux from the winner. mem_wren = d_grant & d_we. mem_din = 0 when fetch wins.
- Owner register (FSM, states NONE / IF_RD / D_RD) updated every edge:
  - IF_RD if if_grant.
  - D_RD if d_grant & ~d_we.
  - NONE otherwise, including data writes.
- Read latency is exactly 1 cycle after the grant cycle:
  - if_rvalid = (owner==IF_RD).
  - d_rvalid = (owner==D_RD).
- Read data path:
  - When rvalid is high, rdata = mem_dout directly.
  - On that edge, the held register captures mem_dout.
  - When rvalid is low, rdata = held register, which stays stable until the next valid.
- starve_cnt (4 bits):
  - 0 when if_req=0 or if_grant=1.
  - +1 when if_req & ~if_grant, saturating at 15.
- conflict_cnt: +1 on each edge with if_req & d_req; saturates at 16'hFFFF, never wraps.
- Back-to-back grants to the same or alternating ports are legal every cycle, giving full throughput.
- A write followed next cycle by a read of the same address returns the new data; this relies on the RAM's write-then-read ordering.
- Reset asserted mid-read: the pending rvalid is dropped, and no rvalid appears after clear is released.
- A requester changing its address without a grant is legal; the arbiter samples only in the grant cycle.

Decomposition:
- Shared package: owner state encoding (NONE=2'd0, IF_RD=2'd1, D_RD=2'd2) and default widths.
- One natural sub-module: sat_counter (parameterised width, inc, clr, synchronous active-low clear). It is instantiated for starve_cnt and conflict_cnt.

Test Plan:
- Fetch only: if_req=1, if_addr=0..3 on consecutive cycles, RAM preloaded MEM[n]=n+0x10.
  - Required: if_grant=1 every cycle.
  - Required: if_rvalid every cycle from cycle 2, data 0x10, 0x11, 0x12, 0x13.
- Simultaneous requests: if_req=1, d_req=1, d_we=0, d_addr=5.
  - Required: d_grant=1, if_grant=0.
  - Required: d_rvalid next cycle with MEM[5].
  - Required: conflict_cnt increments by 1.
- Starvation: both requests held high for 6 cycles, STARVE_LIMIT=4.
  - Required: d granted in cycles 1-4, fetch granted in cycle 5, d granted in cycle 6.
  - Required: starve_cnt returns to 0 after the fetch grant.
- Write then read: d write addr 7 data 0xDEADBEEF, then d read addr 7.
  - Required: mem_wren=1 for the write cycle only, no rvalid for the write.
  - Required: d_rvalid with 0xDEADBEEF.
  - Required: d_rdata holds 0xDEADBEEF afterwards while d_rvalid=0.
- Reset mid-operation: fetch granted, clear=0 at the next edge.
  - Required: if_rvalid=0, held data 0, conflict_cnt=0.
  - Required: grants 0 while clear=0, normal arbitration resumes the cycle after clear=1.
